// File: rtl/step_scheduler_pkg.sv
// Shared types and constants for the step_scheduler block.
package step_sched_pkg;

    localparam int EN_COUNT_W = 16;

    typedef enum logic [1:0] {
        STEP  = 2'b00,
        RUN   = 2'b01,
        BURST = 2'b10,
        RSVD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE_S  = 2'b00,
        RUN_S   = 2'b01,
        BURST_S = 2'b10
    } state_t;

endpackage

// File: rtl/step_scheduler_if.sv
// Control/status bundle between the lab front panel logic and step_scheduler.
// Optional macro STEP_SCHED_CNT_EN adds the en_count status signal.
interface step_scheduler_if #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
);
    import step_sched_pkg::*;

    logic               step_pulse;
    mode_t              mode;
    logic               start;
    logic               stop;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst_len;
    logic               clk_en;
    logic               busy;
    logic               done;
`ifdef STEP_SCHED_CNT_EN
    logic [EN_COUNT_W-1:0] en_count;
`endif

`ifdef STEP_SCHED_CNT_EN
    modport master (output step_pulse, mode, start, stop, div, burst_len,
                    input  clk_en, busy, done, en_count);
    modport slave  (input  step_pulse, mode, start, stop, div, burst_len,
                    output clk_en, busy, done, en_count);
`else
    modport master (output step_pulse, mode, start, stop, div, burst_len,
                    input  clk_en, busy, done);
    modport slave  (input  step_pulse, mode, start, stop, div, burst_len,
                    output clk_en, busy, done);
`endif

endinterface

// File: rtl/en_prescaler.sv
// Period generator for RUN and BURST: ticks once every div_eff cycles of run.
// On clear the count is treated as 0 in that same cycle, so a clear cycle
// with run asserted already counts as the first cycle of the period.
module en_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div_eff,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] cnt_cur;

    // Terminal compare before increment, so the count never wraps.
    always_comb begin
        cnt_cur = clear ? '0 : cnt_q;
        tick    = run && (cnt_cur == (div_eff - DIV_W'(1)));
        cnt_d   = cnt_cur;
        if (tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_cur + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_scheduler.sv
// Clock-enable scheduler: single-step, free-run and fixed-length burst.
// Optional macro STEP_SCHED_CNT_EN adds a running count of issued enables.
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    step_scheduler_if.slave bus
);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] bcnt_q, bcnt_d;
    logic               clk_en_q, clk_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_step;
    logic [DIV_W-1:0]   div_new;
    logic               start_ok;
    logic               ps_clear;
    logic               ps_run;
    logic [DIV_W-1:0]   ps_div;
    logic               ps_tick;

    assign is_step  = (bus.mode == STEP) || (bus.mode == RSVD);
    assign div_new  = (bus.div == '0) ? DIV_W'(1) : bus.div;
    // stop in the same cycle drops the start.
    assign start_ok = (state_q == IDLE_S) && bus.start && !bus.stop &&
                      ((bus.mode == RUN) || (bus.mode == BURST));

    // The prescaler runs from the start cycle itself so div_eff=1 gives an
    // enable right after start; a zero-length burst never runs it, and a
    // burst whose count is complete stops it while the FSM heads to idle.
    assign ps_clear = start_ok;
    assign ps_div   = start_ok ? div_new : div_q;
    assign ps_run   = !bus.stop &&
                      ((start_ok && ((bus.mode == RUN) || (bus.burst_len != '0))) ||
                       (state_q == RUN_S) ||
                       ((state_q == BURST_S) && (bcnt_q != len_q)));

    en_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (ps_clear),
        .run     (ps_run),
        .div_eff (ps_div),
        .tick    (ps_tick)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        clk_en_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE_S: begin
                if (start_ok) begin
                    div_d  = div_new;
                    len_d  = bus.burst_len;
                    bcnt_d = '0;
                    if (bus.mode == RUN) begin
                        state_d  = RUN_S;
                        clk_en_d = ps_tick;
                    end else if (bus.burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = BURST_S;
                        clk_en_d = ps_tick;
                        bcnt_d   = ps_tick ? BURST_W'(1) : '0;
                    end
                end else begin
                    clk_en_d = is_step && bus.step_pulse;
                end
            end
            RUN_S: begin
                if (bus.stop) begin
                    state_d = IDLE_S;
                end else begin
                    clk_en_d = ps_tick;
                end
            end
            BURST_S: begin
                if (bus.stop) begin
                    state_d = IDLE_S;
                end else if (bcnt_q == len_q) begin
                    state_d = IDLE_S;
                    done_d  = 1'b1;
                end else begin
                    clk_en_d = ps_tick;
                    if (ps_tick) begin
                        bcnt_d = bcnt_q + BURST_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase

        busy_d = (state_d != IDLE_S);
    end

    // State, latches and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE_S;
            div_q    <= '0;
            len_q    <= '0;
            bcnt_q   <= '0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.clk_en = clk_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

`ifdef STEP_SCHED_CNT_EN
    logic [EN_COUNT_W-1:0] en_count_q, en_count_d;

    // Count updates in the same cycle the counted enable appears.
    always_comb begin
        en_count_d = en_count_q + EN_COUNT_W'(clk_en_d);
    end

    // Enable counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_count_q <= '0;
        end else begin
            en_count_q <= en_count_d;
        end
    end

    assign bus.en_count = en_count_q;
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler: directed scenarios then random traffic,
// each cycle's expected outputs come from a timestamp-based behavioural model.
module tb_step_scheduler;
    import step_sched_pkg::*;

    localparam int DIV_W   = 16;
    localparam int BURST_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    step_scheduler_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

    step_scheduler #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic        en;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Model state: activity kind (0 idle, 1 run, 2 burst), period, absolute
    // cycle of the next enable, enables still owed in the burst, total count.
    int          m_act    = 0;
    int          m_period = 1;
    int          m_next   = 0;
    int          m_left   = 0;
    logic [15:0] m_cnt    = '0;

    task automatic model(input logic sp, input mode_t m, input logic st, input logic stp,
                         input logic [15:0] dv, input logic [7:0] bl, input logic r);
        int   t;
        int   c;
        exp_t e;
        t = cyc_cnt;
        c = t + 1;
        e.cyc  = c;
        e.en   = 1'b0;
        e.done = 1'b0;
        if (r) begin
            m_act = 0;
            m_cnt = '0;
        end else begin
            case (m_act)
                0: begin
                    if (st && !stp && (m == RUN || m == BURST)) begin
                        m_period = (dv == 0) ? 1 : int'(dv);
                        m_next   = t + m_period;
                        if (m == RUN) begin
                            m_act = 1;
                        end else if (bl == 0) begin
                            e.done = 1'b1;
                        end else begin
                            m_act  = 2;
                            m_left = int'(bl);
                        end
                        if (m_act != 0 && c == m_next) begin
                            e.en   = 1'b1;
                            m_next = m_next + m_period;
                            if (m_act == 2) m_left = m_left - 1;
                        end
                    end else begin
                        e.en = sp && (m == STEP || m == RSVD);
                    end
                end
                1: begin
                    if (stp) begin
                        m_act = 0;
                    end else if (c == m_next) begin
                        e.en   = 1'b1;
                        m_next = m_next + m_period;
                    end
                end
                default: begin
                    if (stp) begin
                        m_act = 0;
                    end else if (m_left == 0) begin
                        m_act  = 0;
                        e.done = 1'b1;
                    end else if (c == m_next) begin
                        e.en   = 1'b1;
                        m_next = m_next + m_period;
                        m_left = m_left - 1;
                    end
                end
            endcase
            if (e.en) m_cnt = m_cnt + 16'd1;
        end
        e.busy = (m_act != 0);
        e.cnt  = m_cnt;
        q.push_back(e);
    endtask

    task automatic drive(input logic sp, input mode_t m, input logic st, input logic stp,
                         input logic [15:0] dv, input logic [7:0] bl, input logic r);
        @(posedge clk);
        #1;
        bus.step_pulse = sp;
        bus.mode       = m;
        bus.start      = st;
        bus.stop       = stp;
        bus.div        = dv;
        bus.burst_len  = bl;
        rst            = r;
        model(sp, m, st, stp, dv, bl, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, STEP, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    endtask

    task automatic chk(input string name, input int c, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
        end
    endtask

    // Monitor: pops the expectation for the current cycle and compares.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc == cyc_cnt) begin
                exp_t e;
                e = q.pop_front();
                chk("clk_en", e.cyc, {15'd0, bus.clk_en}, {15'd0, e.en});
                chk("busy",   e.cyc, {15'd0, bus.busy},   {15'd0, e.busy});
                chk("done",   e.cyc, {15'd0, bus.done},   {15'd0, e.done});
`ifdef STEP_SCHED_CNT_EN
                chk("en_count", e.cyc, bus.en_count, e.cnt);
`endif
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.step_pulse = 1'b0;
        bus.mode       = STEP;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.div        = '0;
        bus.burst_len  = '0;

        // Reset state.
        drive(1'b1, STEP, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
        drive(1'b0, STEP, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
        idle(3);

        // STEP: back-to-back pulses, reserved mode acts as STEP.
        drive(1'b1, STEP, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        drive(1'b1, STEP, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        idle(2);
        drive(1'b1, RSVD, 1'b1, 1'b0, 16'd4, 8'd3, 1'b0);
        idle(2);

        // RUN div=4 with stray step pulses and a div change, then stop.
        drive(1'b0, RUN, 1'b1, 1'b0, 16'd4, 8'd0, 1'b0);
        idle(5);
        drive(1'b1, STEP, 1'b0, 1'b0, 16'd1, 8'd0, 1'b0);
        idle(7);
        drive(1'b0, STEP, 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        idle(4);

        // RUN div=0: enable every cycle.
        drive(1'b0, RUN, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
        idle(6);
        drive(1'b0, STEP, 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        idle(2);

        // BURST div=3 len=5, then a new start on the done cycle.
        drive(1'b0, BURST, 1'b1, 1'b0, 16'd3, 8'd5, 1'b0);
        idle(15);
        drive(1'b0, BURST, 1'b1, 1'b0, 16'd1, 8'd2, 1'b0);
        idle(5);

        // Zero-length burst and start+stop collision.
        drive(1'b0, BURST, 1'b1, 1'b0, 16'd3, 8'd0, 1'b0);
        idle(2);
        drive(1'b0, RUN, 1'b1, 1'b1, 16'd1, 8'd0, 1'b0);
        drive(1'b0, BURST, 1'b1, 1'b1, 16'd1, 8'd4, 1'b0);
        idle(3);

        // Stop on a cycle where an enable is due, then reset mid-burst.
        drive(1'b0, RUN, 1'b1, 1'b0, 16'd2, 8'd0, 1'b0);
        idle(2);
        drive(1'b0, STEP, 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        idle(2);
        drive(1'b0, BURST, 1'b1, 1'b0, 16'd3, 8'd5, 1'b0);
        idle(6);
        drive(1'b0, STEP, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        sp, st, stp, r;
            mode_t       m;
            logic [15:0] dv;
            logic [7:0]  bl;
            sp  = ($urandom_range(0, 2) == 0);
            m   = mode_t'($urandom_range(0, 3));
            st  = ($urandom_range(0, 7) == 0);
            stp = ($urandom_range(0, 39) == 0);
            dv  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 20))
                                              : 16'($urandom_range(0, 5));
            bl  = 8'($urandom_range(0, 6));
            r   = ($urandom_range(0, 299) == 0);
            drive(sp, m, st, stp, dv, bl, r);
        end

        idle(3);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
